// File: rtl/pkt_pkg.sv
// Shared definitions for the packet-triggered backscatter window controller:
// state encoding, default clock rate and a saturating counter helper.
package pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEASURE = 2'b01,
    GUARD   = 2'b10,
    WINDOW  = 2'b11
  } state_e;

  localparam int CNT_PER_US = 20;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/pkt_tx_window.sv
// Measures each detected packet; a packet long enough opens a backscatter
// transmit window after a guard delay, a too-short one is flagged as rejected.
module pkt_tx_window #(
  parameter int CNT_PER_US = pkt_pkg::CNT_PER_US,
  parameter int MIN_PKT_US = 8,
  parameter int GUARD_US   = 10,
  parameter int WIN_US     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_in,
  input  logic       enable,
  output logic       tx_en,
  output logic       tx_start,
  output logic       reject,
  output logic       busy,
  output logic [7:0] pkt_cnt
);
  import pkt_pkg::*;

  localparam logic [15:0] MIN_CYC   = 16'(CNT_PER_US * MIN_PKT_US);
  localparam logic [15:0] GUARD_CYC = 16'(CNT_PER_US * GUARD_US);
  localparam logic [15:0] WIN_CYC   = 16'(CNT_PER_US * WIN_US);

  state_e      state_r, state_n;
  logic        pkt_d_r;
  logic        rise_s;
  logic [15:0] len_cnt_r, len_cnt_n;
  logic [15:0] tmr_r, tmr_n;
  logic [7:0]  pkt_cnt_r, pkt_cnt_n;
  logic        tx_en_s, tx_start_s, reject_s, busy_s;
  logic        tx_en_r, tx_start_r, reject_r, busy_r;

  assign rise_s = pkt_in & ~pkt_d_r;

  // State, counters and the delayed packet level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pkt_d_r   <= 1'b0;
      len_cnt_r <= 16'd0;
      tmr_r     <= 16'd0;
      pkt_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_n;
      pkt_d_r   <= pkt_in;
      len_cnt_r <= len_cnt_n;
      tmr_r     <= tmr_n;
      pkt_cnt_r <= pkt_cnt_n;
    end
  end

  // Next-state logic; a disabled block falls back to IDLE from anywhere
  always_comb begin
    state_n   = state_r;
    len_cnt_n = len_cnt_r;
    tmr_n     = tmr_r;
    pkt_cnt_n = pkt_cnt_r;
    if (!enable) begin
      state_n   = IDLE;
      len_cnt_n = 16'd0;
      tmr_n     = 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_n   = MEASURE;
            len_cnt_n = 16'd1;
          end else begin
            state_n = IDLE;
          end
        end
        MEASURE: begin
          if (pkt_in) begin
            len_cnt_n = sat_inc16(len_cnt_r);
          end else if (len_cnt_r >= MIN_CYC) begin
            state_n   = GUARD;
            tmr_n     = 16'd0;
            pkt_cnt_n = pkt_cnt_r + 8'd1;
          end else begin
            state_n   = IDLE;
            len_cnt_n = 16'd0;
          end
        end
        GUARD: begin
          // A new packet during the guard supersedes the pending window
          if (rise_s) begin
            state_n   = MEASURE;
            len_cnt_n = 16'd1;
            tmr_n     = 16'd0;
          end else if (tmr_r == GUARD_CYC - 16'd1) begin
            state_n = WINDOW;
            tmr_n   = 16'd0;
          end else begin
            tmr_n = tmr_r + 16'd1;
          end
        end
        WINDOW: begin
          if (tmr_r == WIN_CYC - 16'd1) begin
            state_n = IDLE;
            tmr_n   = 16'd0;
          end else begin
            tmr_n = tmr_r + 16'd1;
          end
        end
        default: begin
          state_n = IDLE;
          tmr_n   = 16'd0;
        end
      endcase
    end
  end

  // Output decode from the current state, gated so enable drops them at once
  always_comb begin
    tx_en_s    = enable & (state_r == WINDOW);
    tx_start_s = tx_en_s & (tmr_r == 16'd0);
    busy_s     = enable & (state_r != IDLE);
    reject_s   = enable & (state_r == MEASURE) & ~pkt_in & (len_cnt_r < MIN_CYC);
  end

  // Output registers; reset clears them without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en_r    <= 1'b0;
      tx_start_r <= 1'b0;
      reject_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      tx_en_r    <= tx_en_s;
      tx_start_r <= tx_start_s;
      reject_r   <= reject_s;
      busy_r     <= busy_s;
    end
  end

  assign tx_en    = tx_en_r;
  assign tx_start = tx_start_r;
  assign reject   = reject_r;
  assign busy     = busy_r;
  assign pkt_cnt  = pkt_cnt_r;

endmodule

// File: tb/tb_pkt_tx_window.sv
// Scoreboard bench for pkt_tx_window at default parameters: the stimulus queues
// expected tx_start/reject events, a negedge monitor pops and compares them.
module tb_pkt_tx_window;

  localparam int GUARD_CYC = 200;
  localparam int WIN_CYC   = 2000;
  localparam int K_START   = 0;
  localparam int K_REJECT  = 1;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
    int len;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       pkt_in;
  logic       enable;
  logic       tx_en;
  logic       tx_start;
  logic       reject;
  logic       busy;
  logic [7:0] pkt_cnt;

  exp_t sb_q[$];
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_err     = 0;
  int   exp_cnt   = 0;
  int   in_win    = 0;
  int   rise_cyc  = 0;
  int   exp_len   = 0;

  pkt_tx_window dut (
    .clk      (clk),
    .rst      (rst),
    .pkt_in   (pkt_in),
    .enable   (enable),
    .tx_en    (tx_en),
    .tx_start (tx_start),
    .reject   (reject),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Packet high for len sampled edges; n is the edge that first samples it low
  task automatic pulse(input int len, output int n);
    pkt_in = 1'b1;
    tick(len);
    pkt_in = 1'b0;
    n = cyc + 1;
  endtask

  task automatic push_start(input int n, input int len);
    exp_t e;
    e.kind = K_START;
    e.cyc  = n + 1 + GUARD_CYC;
    e.cnt  = exp_cnt;
    e.len  = len;
    sb_q.push_back(e);
  endtask

  task automatic push_reject(input int n);
    exp_t e;
    e.kind = K_REJECT;
    e.cyc  = n;
    e.cnt  = exp_cnt;
    e.len  = 0;
    sb_q.push_back(e);
  endtask

  task automatic qualify();
    exp_cnt = (exp_cnt + 1) % 256;
  endtask

  // Monitor: compares every pulse event and every completed window length
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_win = 0;
    end else begin
      if (tx_start || reject) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_event", tx_start ? K_START : K_REJECT, -1);
        end else begin
          e = sb_q.pop_front();
          chk("event_kind", tx_start ? K_START : K_REJECT, e.kind);
          chk("event_cycle", cyc, e.cyc);
          chk("event_pkt_cnt", int'(pkt_cnt), e.cnt);
          if (e.kind == K_START) exp_len = e.len;
        end
      end
      if (tx_en && in_win == 0) begin
        in_win   = 1;
        rise_cyc = cyc;
      end else if (!tx_en && in_win != 0) begin
        in_win = 0;
        if (exp_len != 0) chk("window_len", cyc - rise_cyc, exp_len);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst    = 1'b1;
    pkt_in = 1'b0;
    enable = 1'b1;
    tick(3);
    chk("reset_tx_en", int'(tx_en), 0);
    chk("reset_tx_start", int'(tx_start), 0);
    chk("reset_reject", int'(reject), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pkt_cnt", int'(pkt_cnt), 0);
    rst = 1'b0;
    tick(2);

    // Nominal 400-cycle packet
    pulse(400, n);
    qualify();
    push_start(n, WIN_CYC);
    tick(GUARD_CYC / 2);
    chk("busy_in_guard", int'(busy), 1);
    tick(GUARD_CYC + WIN_CYC + 20);
    chk("t1_pkt_cnt", int'(pkt_cnt), 1);
    chk("t1_busy_after", int'(busy), 0);

    // Length threshold: 159 rejects, 160 qualifies
    pulse(159, n);
    push_reject(n);
    tick(10);
    chk("short_no_tx", int'(tx_en), 0);
    chk("short_pkt_cnt", int'(pkt_cnt), 1);
    pulse(160, n);
    qualify();
    push_start(n, WIN_CYC);
    tick(GUARD_CYC + WIN_CYC + 20);

    // Second packet arriving 50 cycles into the guard replaces the first window
    pulse(200, n);
    qualify();
    tick(50);
    pulse(300, n);
    qualify();
    push_start(n, WIN_CYC);
    tick(GUARD_CYC + WIN_CYC + 20);
    chk("restart_pkt_cnt", int'(pkt_cnt), 4);

    // Drop enable after 500 window cycles
    pulse(200, n);
    qualify();
    push_start(n, 500);
    while (cyc < n + GUARD_CYC + 500) tick(1);
    enable = 1'b0;
    tick(1);
    chk("disable_tx_en", int'(tx_en), 0);
    chk("disable_busy", int'(busy), 0);
    chk("disable_pkt_cnt", int'(pkt_cnt), exp_cnt);
    enable = 1'b1;
    tick(5);

    // Asynchronous reset in the middle of a window
    pulse(200, n);
    qualify();
    push_start(n, 0);
    while (cyc < n + GUARD_CYC + 101) tick(1);
    #3 rst = 1'b1;
    #1;
    chk("arst_tx_en", int'(tx_en), 0);
    chk("arst_tx_start", int'(tx_start), 0);
    chk("arst_reject", int'(reject), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_pkt_cnt", int'(pkt_cnt), 0);
    exp_cnt = 0;
    pkt_in  = 1'b1;
    tick(3);
    rst = 1'b0;
    // pkt_in already high at release counts as a rising edge
    pulse(160, n);
    qualify();
    push_start(n, WIN_CYC);
    tick(GUARD_CYC + WIN_CYC + 20);
    chk("post_reset_pkt_cnt", int'(pkt_cnt), 1);

    // 256 qualified packets wrap the counter; chained so only the last opens a window
    rst = 1'b1;
    tick(2);
    rst     = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      pulse(160, n);
      qualify();
      tick(3);
    end
    chk("cnt_255", int'(pkt_cnt), 255);
    pulse(160, n);
    qualify();
    push_start(n, WIN_CYC);

    // Packet held high across the end of the window must not start a measurement
    while (cyc < n + GUARD_CYC + 101) tick(1);
    pkt_in = 1'b1;
    while (cyc < n + GUARD_CYC + WIN_CYC + 50) tick(1);
    chk("held_busy", int'(busy), 0);
    chk("held_tx_en", int'(tx_en), 0);
    chk("wrap_pkt_cnt", int'(pkt_cnt), 0);
    pkt_in = 1'b0;
    tick(5);
    pulse(160, n);
    qualify();
    push_start(n, WIN_CYC);
    tick(GUARD_CYC + WIN_CYC + 20);
    chk("final_pkt_cnt", int'(pkt_cnt), 1);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
